// File: rtl/ifid_stage_pkg.sv
// Shared definitions for the IF/ID stage: NOP encoding, HALT opcode,
// register-field positions and the stage state encoding.
package ifid_stage_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  OPC_HALT  = 5'b00000;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int RS_MSB  = 10;
  localparam int RS_LSB  = 8;
  localparam int RT_MSB  = 7;
  localparam int RT_LSB  = 5;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_IMEM_WAIT = 2'b01,
    ST_HALTED    = 2'b10
  } ifid_state_e;

endpackage

// File: rtl/ifid_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds a source
// register of the instruction currently in decode.
module ifid_hazard_detect
  import ifid_stage_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic              valid_id,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              use_rs_id,
  input  logic              use_rt_id,
  input  logic              memread_ex,
  input  logic [REG_AW-1:0] rd_ex,
  output logic              load_use
);

  // R0 is compared like any other register.
  assign load_use = valid_id & memread_ex &
                    ((use_rs_id & (rd_ex == rs_id)) |
                     (use_rt_id & (rd_ex == rt_id)));

endmodule

// File: rtl/ifid_stage.sv
// IF/ID pipeline register with fetch handshake, load-use stall, flush and
// HALT freeze. Optional IFID_PERF_EN adds saturating stall/flush counters.
module ifid_stage
  import ifid_stage_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          REG_AW    = 3,
  parameter logic [15:0] NOP_VALUE = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instr_if,
  input  logic [DATA_W-1:0] pc_add2_if,
  input  logic              imem_done,
  output logic              imem_req,
  input  logic              flush,
  input  logic              memread_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              use_rs_id,
  input  logic              use_rt_id,
  output logic [DATA_W-1:0] instr_id,
  output logic [DATA_W-1:0] pc_add2_id,
  output logic              valid_id,
  output logic              stall_pc,
  output logic              bubble_ex
`ifdef IFID_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  ifid_state_e       state_q, state_d;
  logic [DATA_W-1:0] instr_d, pc_d;
  logic              valid_d;
  logic              load_use, halt_id;

  ifid_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .valid_id   (valid_id),
    .rs_id      (instr_id[RS_MSB:RS_LSB]),
    .rt_id      (instr_id[RT_MSB:RT_LSB]),
    .use_rs_id  (use_rs_id),
    .use_rt_id  (use_rt_id),
    .memread_ex (memread_ex),
    .rd_ex      (rd_ex),
    .load_use   (load_use)
  );

  assign halt_id = valid_id & (instr_id[OPC_MSB:OPC_LSB] == OPC_HALT);

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_id;
    pc_d      = pc_add2_id;
    valid_d   = valid_id;
    imem_req  = 1'b1;
    stall_pc  = 1'b0;
    bubble_ex = 1'b0;
    if (rst) begin
      state_d = ST_RUN;
    end else if (state_q == ST_HALTED) begin
      // Frozen until reset; flushes are ignored here.
      imem_req  = 1'b0;
      stall_pc  = 1'b1;
      bubble_ex = 1'b1;
      instr_d   = NOP_VALUE;
      valid_d   = 1'b0;
    end else if (flush) begin
      bubble_ex = 1'b1;
      instr_d   = NOP_VALUE;
      valid_d   = 1'b0;
      state_d   = ST_RUN;
    end else if (load_use) begin
      stall_pc  = 1'b1;
      bubble_ex = 1'b1;
    end else begin
      if (imem_done) begin
        instr_d = instr_if;
        pc_d    = pc_add2_if;
        valid_d = 1'b1;
        state_d = ST_RUN;
      end else begin
        stall_pc = 1'b1;
        instr_d  = NOP_VALUE;
        valid_d  = 1'b0;
        state_d  = ST_IMEM_WAIT;
      end
      // HALT moves on to ID/EX this cycle; decode goes dead behind it.
      if (halt_id) begin
        state_d = ST_HALTED;
        instr_d = NOP_VALUE;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      instr_id   <= NOP_VALUE;
      pc_add2_id <= '0;
      valid_id   <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_id   <= instr_d;
      pc_add2_id <= pc_d;
      valid_id   <= valid_d;
    end
  end

`ifdef IFID_PERF_EN
  logic active, stall_ev, flush_ev;
  assign active   = (state_q != ST_HALTED);
  assign flush_ev = active & flush;
  assign stall_ev = active & ~flush & (load_use | ~imem_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush_ev && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifid_stage.sv
// Directed bench for ifid_stage: reset, streaming, load-use, memory wait,
// flush priority and HALT freeze.
module tb_ifid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_if, pc_add2_if;
  logic        imem_done, imem_req, flush, memread_ex;
  logic [2:0]  rd_ex;
  logic        use_rs_id, use_rt_id;
  logic [15:0] instr_id, pc_add2_id;
  logic        valid_id, stall_pc, bubble_ex;
`ifdef IFID_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int cmp_cnt = 0;
  int mis_cnt = 0;

  always #5 clk = ~clk;

  ifid_stage dut (
    .clk(clk), .rst(rst), .instr_if(instr_if), .pc_add2_if(pc_add2_if),
    .imem_done(imem_done), .imem_req(imem_req), .flush(flush),
    .memread_ex(memread_ex), .rd_ex(rd_ex), .use_rs_id(use_rs_id),
    .use_rt_id(use_rt_id), .instr_id(instr_id), .pc_add2_id(pc_add2_id),
    .valid_id(valid_id), .stall_pc(stall_pc), .bubble_ex(bubble_ex)
`ifdef IFID_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; memread_ex = 0; rd_ex = 3'd0; use_rs_id = 0; use_rt_id = 0;
    imem_done = 0; instr_if = 16'h0; pc_add2_if = 16'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    cmp_cnt += 5;
    if (instr_id !== 16'h0800) begin mis_cnt++; $display("FAIL reset_instr got %h want 0800", instr_id); end
    if (pc_add2_id !== 16'h0) begin mis_cnt++; $display("FAIL reset_pc got %h want 0000", pc_add2_id); end
    if (valid_id !== 1'b0) begin mis_cnt++; $display("FAIL reset_valid got %b want 0", valid_id); end
    if (imem_req !== 1'b1) begin mis_cnt++; $display("FAIL reset_imem_req got %b want 1", imem_req); end
    if (stall_pc !== 1'b0 || bubble_ex !== 1'b0) begin
      mis_cnt++; $display("FAIL reset_stall_bubble got %b%b want 00", stall_pc, bubble_ex);
    end
    rst = 0;
  endtask

  task automatic test_stream();
    imem_done = 1; instr_if = 16'hC123; pc_add2_if = 16'h0002;
    @(negedge clk);
    cmp_cnt++;
    if (stall_pc !== 1'b0 || bubble_ex !== 1'b0) begin
      mis_cnt++; $display("FAIL stream_ctrl got %b%b want 00", stall_pc, bubble_ex);
    end
    step();
    cmp_cnt += 3;
    if (instr_id !== 16'hC123) begin mis_cnt++; $display("FAIL stream_instr got %h want c123", instr_id); end
    if (pc_add2_id !== 16'h0002) begin mis_cnt++; $display("FAIL stream_pc got %h want 0002", pc_add2_id); end
    if (valid_id !== 1'b1) begin mis_cnt++; $display("FAIL stream_valid got %b want 1", valid_id); end
    instr_if = 16'hA246; pc_add2_if = 16'h0004;
    step();
    cmp_cnt += 2;
    if (instr_id !== 16'hA246) begin mis_cnt++; $display("FAIL b2b_instr got %h want a246", instr_id); end
    if (pc_add2_id !== 16'h0004) begin mis_cnt++; $display("FAIL b2b_pc got %h want 0004", pc_add2_id); end
  endtask

  task automatic test_load_use();
    imem_done = 1; instr_if = 16'hDA04; pc_add2_if = 16'h0006;
    step();
    memread_ex = 1; rd_ex = 3'b010; use_rs_id = 1; instr_if = 16'h1111; pc_add2_if = 16'h0008;
    @(negedge clk);
    cmp_cnt += 2;
    if (stall_pc !== 1'b1 || bubble_ex !== 1'b1) begin
      mis_cnt++; $display("FAIL lu_ctrl got %b%b want 11", stall_pc, bubble_ex);
    end
    if (imem_req !== 1'b1) begin mis_cnt++; $display("FAIL lu_imem_req got %b want 1", imem_req); end
    step();
    cmp_cnt += 2;
    if (instr_id !== 16'hDA04) begin mis_cnt++; $display("FAIL lu_hold_instr got %h want da04", instr_id); end
    if (valid_id !== 1'b1 || pc_add2_id !== 16'h0006) begin
      mis_cnt++; $display("FAIL lu_hold_valid_pc got %b/%h want 1/0006", valid_id, pc_add2_id);
    end
    // ID/EX now holds the bubble, hazard clears.
    memread_ex = 0;
    @(negedge clk);
    cmp_cnt++;
    if (stall_pc !== 1'b0 || bubble_ex !== 1'b0) begin
      mis_cnt++; $display("FAIL lu_release got %b%b want 00", stall_pc, bubble_ex);
    end
    step();
    cmp_cnt++;
    if (instr_id !== 16'h1111) begin mis_cnt++; $display("FAIL lu_advance got %h want 1111", instr_id); end
    // rt field of 16'h1111 is 3'b000: R0 is matched like any register.
    use_rs_id = 0; use_rt_id = 1; memread_ex = 1; rd_ex = 3'b000;
    @(negedge clk);
    cmp_cnt++;
    if (stall_pc !== 1'b1 || bubble_ex !== 1'b1) begin
      mis_cnt++; $display("FAIL lu_rt_r0 got %b%b want 11", stall_pc, bubble_ex);
    end
    rd_ex = 3'b001;
    @(negedge clk);
    cmp_cnt++;
    if (bubble_ex !== 1'b0) begin mis_cnt++; $display("FAIL lu_rt_nomatch got %b want 0", bubble_ex); end
    memread_ex = 0; use_rt_id = 0;
  endtask

  task automatic test_mem_wait();
    imem_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp_cnt += 2;
      if (stall_pc !== 1'b1) begin mis_cnt++; $display("FAIL wait_stall[%0d] got %b want 1", i, stall_pc); end
      if (imem_req !== 1'b1) begin mis_cnt++; $display("FAIL wait_req[%0d] got %b want 1", i, imem_req); end
      step();
      cmp_cnt++;
      if (valid_id !== 1'b0 || instr_id !== 16'h0800) begin
        mis_cnt++; $display("FAIL wait_nop[%0d] got %b/%h want 0/0800", i, valid_id, instr_id);
      end
    end
    imem_done = 1; instr_if = 16'h2345; pc_add2_if = 16'h000A;
    @(negedge clk);
    cmp_cnt++;
    if (stall_pc !== 1'b0) begin mis_cnt++; $display("FAIL wait_done_stall got %b want 0", stall_pc); end
    step();
    cmp_cnt++;
    if (instr_id !== 16'h2345 || valid_id !== 1'b1) begin
      mis_cnt++; $display("FAIL wait_capture got %h/%b want 2345/1", instr_id, valid_id);
    end
  endtask

  task automatic test_flush();
    imem_done = 1; instr_if = 16'hDA04; pc_add2_if = 16'h000C;
    step();
    flush = 1; memread_ex = 1; rd_ex = 3'b010; use_rs_id = 1; instr_if = 16'hC123;
    @(negedge clk);
    cmp_cnt++;
    if (stall_pc !== 1'b0 || bubble_ex !== 1'b1) begin
      mis_cnt++; $display("FAIL flush_ctrl got %b%b want 01", stall_pc, bubble_ex);
    end
    step();
    cmp_cnt++;
    if (instr_id !== 16'h0800 || valid_id !== 1'b0) begin
      mis_cnt++; $display("FAIL flush_nop got %h/%b want 0800/0", instr_id, valid_id);
    end
    flush = 0; memread_ex = 0; use_rs_id = 0;
  endtask

  task automatic test_halt_flush();
    imem_done = 1; instr_if = 16'h0000; pc_add2_if = 16'h000E;
    step();
    flush = 1; instr_if = 16'hC123; pc_add2_if = 16'h0010;
    step();
    flush = 0;
    @(negedge clk);
    cmp_cnt++;
    if (imem_req !== 1'b1) begin mis_cnt++; $display("FAIL halt_cancel_req got %b want 1", imem_req); end
    step();
    cmp_cnt++;
    if (instr_id !== 16'hC123 || valid_id !== 1'b1) begin
      mis_cnt++; $display("FAIL halt_cancel_run got %h/%b want c123/1", instr_id, valid_id);
    end
  endtask

  task automatic test_halt();
    imem_done = 1; instr_if = 16'h0000; pc_add2_if = 16'h0012;
    step();
    instr_if = 16'hC123; pc_add2_if = 16'h0014;
    @(negedge clk);
    cmp_cnt++;
    if (stall_pc !== 1'b0 || bubble_ex !== 1'b0) begin
      mis_cnt++; $display("FAIL halt_advance got %b%b want 00", stall_pc, bubble_ex);
    end
    step();
    for (int i = 0; i < 20; i++) begin
      flush = (i % 5 == 2);
      @(negedge clk);
      cmp_cnt++;
      if (imem_req !== 1'b0 || stall_pc !== 1'b1 || bubble_ex !== 1'b1) begin
        mis_cnt++; $display("FAIL halted_ctrl[%0d] got req=%b stall=%b bub=%b want 0 1 1", i, imem_req, stall_pc, bubble_ex);
      end
      step();
      cmp_cnt++;
      if (instr_id !== 16'h0800 || valid_id !== 1'b0) begin
        mis_cnt++; $display("FAIL halted_hold[%0d] got %h/%b want 0800/0", i, instr_id, valid_id);
      end
    end
    flush = 0;
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    cmp_cnt++;
    if (imem_req !== 1'b1) begin mis_cnt++; $display("FAIL halt_reset_exit got %b want 1", imem_req); end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_stream();
    test_load_use();
    test_mem_wait();
    test_flush();
    test_halt_flush();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
